gesture_uart_reporter: RTL
==========================

Name: gesture_uart_reporter

Overview:
- Consumes the classifier's final gesture report (gesture, single-cycle gesture_valid strobe, 4-bit confidence) and transmits each report as a 3-byte framed packet on a UART TX line to the host.
- Sits at the far end of the gesture output path.
- Decouples the bursty strobe from the slow serial line with a small FIFO.
- Counts reports lost to overflow.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, report FIFO entries; power of two, >= 2.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- gesture  in  2  classified gesture code; sampled only when gesture_valid=1.
- gesture_valid  in  1  single-cycle report strobe; no backpressure exists.
- gesture_confidence  in  4  confidence 0..15; sampled with gesture.
- uart_tx  out  1  serial line; 8N1, LSB first, idle high.
- tx_busy  out  1  high while a frame is on the line.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  8  saturating count of reports lost to a full FIFO.

Behaviour:
- Reset (async assert, sync release):
  - uart_tx=1, tx_busy=0, fifo_level=0, drop_count=0.
  - FIFO emptied, framer in IDLE.
  - Assertion mid-frame truncates the frame immediately; the line returns high with no partial stop bit.
- Push:
  - On a clk edge with gesture_valid=1, the entry {gesture_confidence, gesture} (6 bits) is written if the FIFO is not full.
  - Fullness is evaluated before any same-cycle pop, so a simultaneous pop does not make room.
  - If the FIFO is full, the report is discarded and drop_count increments, saturating at 255.
- Pop: when the framer is IDLE and the FIFO is non-empty, it pops one entry on that edge. A simultaneous push and pop leaves fifo_level unchanged.
- Frame content:
  - Byte0 = HEADER_BYTE.
  - Byte1 = {confidence[3:0], 2'b00, gesture[1:0]}.
  - Byte2 = Byte0 XOR Byte1.
- Framer FSM:
  - States: IDLE, START, DATA, STOP; byte_idx counts 0..2.
  - IDLE -> START on pop.
  - START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles -> STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. If byte_idx<2, increment byte_idx and go to START; else go to IDLE.
  - No idle gap between bytes within a frame.
  - Back-to-back frames: when the FIFO is non-empty at the end of the last stop bit, the framer re-enters IDLE for exactly 1 cycle before the next pop.
- Latency: with the FIFO empty and the framer IDLE, a strobe sampled at edge t is popped at edge t+1, and uart_tx falls after edge t+2.
- Frame duration: exactly 30*CLKS_PER_BIT cycles from the start-bit falling edge to the end of the third stop bit.
- tx_busy: rises with the first start bit; falls after the final stop bit.
- uart_tx: registered output, glitch-free.
- Counters:
  - Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Bit index: 0..7.
  - All counters wrap to 0 on state change.
- gesture_valid held high on consecutive cycles: each cycle is a separate report.

Decomposition:
- Shared package gesture_pkg:
  - Frame constants: HEADER_BYTE default, FRAME_BYTES=3.
  - Report payload typedef (confidence + gesture).
  - Framer state enum.
- Sub-module uart_tx_byte: one 8N1 byte per load/done handshake, parameterised by CLKS_PER_BIT.
- Top level holds the FIFO, drop counter and 3-byte sequencer.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Single report, gesture=2, confidence=9: line carries bytes A5, 92, 37; start bit falls after edge t+2; each bit is 4 cycles wide; tx_busy is high for exactly 120 cycles.
- 6 strobes on consecutive cycles with an idle framer, FIFO_DEPTH=4: 5 frames are sent in order, drop_count=1, fifo_level peaks at 4, and each inter-frame gap is 1 idle-high cycle.
- 300 strobes while the first frame is transmitting: drop_count saturates at 255 and does not wrap; the FIFO holds the first 4 post-pop reports.
- Reset asserted mid-DATA of byte1: uart_tx is immediately 1, tx_busy=0, fifo_level=0, drop_count=0; a new report afterwards produces a clean full frame.
- gesture=3, confidence=15 with CLKS_PER_BIT=104: bytes A5, F3, 56; bit widths are exactly 104 cycles; frame length is 3120 cycles.

Source files
------------

// File: rtl/gesture_uart_reporter_pkg.sv
// Shared frame constants, report payload and framer state for the gesture UART reporter.
package gesture_pkg;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES         = 3;

    typedef struct packed {
        logic [3:0] confidence;
        logic [1:0] gesture;
    } report_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } framer_state_t;

    // Byte idx of the frame for a report: header, payload, then header^payload check byte.
    function automatic logic [7:0] frame_byte(input report_t rpt, input logic [1:0] idx,
                                              input logic [7:0] header);
        logic [7:0] payload;
        payload = {rpt.confidence, 2'b00, rpt.gesture};
        case (idx)
            2'd0:    frame_byte = header;
            2'd1:    frame_byte = payload;
            default: frame_byte = header ^ payload;
        endcase
    endfunction

endpackage

// File: rtl/gesture_uart_reporter_tx_byte.sv
// 8N1 byte transmitter; a load accepted on the last stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
    import gesture_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic       idle_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int            TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    framer_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, busy_q;
    logic          bit_end;

    assign bit_end = (timer_q == T_LAST);
    assign done_o  = (state_q == ST_STOP) && bit_end;
    assign idle_o  = (state_q == ST_IDLE);
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                bit_d   = '0;
                if (load_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    timer_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (load_i) begin
                        state_d = ST_START;
                        shift_d = data_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // The line and busy flag are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= (state_q != ST_IDLE);
            case (state_q)
                ST_START: tx_q <= 1'b0;
                ST_DATA:  tx_q <= shift_q[bit_q];
                default:  tx_q <= 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/gesture_uart_reporter.sv
// Buffers gesture reports in a small FIFO and sends each as a 3-byte framed UART packet.
module gesture_uart_reporter
    import gesture_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  gesture,
    input  logic                        gesture_valid,
    input  logic [3:0]                  gesture_confidence,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  drop_count
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]  LAST_BYTE = 2'(FRAME_BYTES - 1);

    report_t       mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    drop_q;
    logic [1:0]    byte_idx_q, byte_idx_d;
    report_t       cur_q, load_rpt;
    logic [7:0]    load_byte;
    logic          full, empty, push, pop, drop, load, done, idle;

    // Fullness is judged on the pre-edge level, so a same-cycle pop never frees a slot.
    assign full     = (level_q == DEPTH);
    assign empty    = (level_q == '0);
    assign push     = gesture_valid && !full;
    assign drop     = gesture_valid && full;
    assign pop      = idle && !empty;
    assign level_d  = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign load_rpt = pop ? mem_q[rd_ptr_q] : cur_q;

    always_comb begin
        byte_idx_d = byte_idx_q;
        load       = 1'b0;
        if (pop) begin
            load       = 1'b1;
            byte_idx_d = 2'd0;
        end else if (done) begin
            if (byte_idx_q < LAST_BYTE) begin
                load       = 1'b1;
                byte_idx_d = byte_idx_q + 2'd1;
            end else begin
                byte_idx_d = 2'd0;
            end
        end
        load_byte = frame_byte(load_rpt, byte_idx_d, HEADER_BYTE);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {gesture_confidence, gesture};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            byte_idx_q <= '0;
            cur_q      <= '0;
        end else begin
            level_q    <= level_d;
            byte_idx_q <= byte_idx_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                cur_q    <= mem_q[rd_ptr_q];
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .data_i (load_byte),
        .done_o (done),
        .idle_o (idle),
        .tx_o   (uart_tx),
        .busy_o (tx_busy)
    );

    assign fifo_level = level_q;
    assign drop_count = drop_q;

endmodule
